// File: rtl/uigr_pad_sniffer.sv
// uigr_pad_sniffer
//   Passive snooper on the SNES controller port. Synchronises and deglitches the three pad
//   lines, reassembles each poll into an active-high button word in uIGR bit order, flags
//   polls cut short by a new latch, and reports when the console stops polling.
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   gamepad_data     pad serial data (active-low, async)
//   gamepad_clk      pad shift clock (async)
//   gamepad_latch    pad latch (active-high, async)
//   buttons          last complete poll, active-high
//   frame_valid      1-cycle pulse when buttons is updated
//   frame_changed    1-cycle pulse with frame_valid when the word changed
//   frame_error      1-cycle pulse when a poll is aborted early
//   latch_tick       1-cycle pulse per filtered latch rising edge
//   polling_lost     level, no latch seen for TIMEOUT_CYCLES
module uigr_pad_sniffer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned GLITCH_CYCLES  = 4,
    parameter int unsigned FRAME_BITS     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gamepad_data,
    input  logic        gamepad_clk,
    input  logic        gamepad_latch,
    output logic [15:0] buttons,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        frame_error,
    output logic        latch_tick,
    output logic        polling_lost
);

    // Line vector order: [0]=latch, [1]=clk, [2]=data. Idle levels: latch low, clk/data high.
    localparam logic [2:0] LINE_RST = 3'b110;
    localparam int unsigned GCW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StLatched, StShift} state_e;

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  filt_q, filt_d;
    logic [2:0][GCW-1:0]         gcnt_q, gcnt_d;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  count_inc;
    logic [15:0] shadow_q, shadow_d;
    logic        done_q, done_d;
    logic [15:0] buttons_q, buttons_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_changed_q, frame_changed_d;
    logic        frame_error_q, frame_error_d;
    logic        latch_tick_q, latch_tick_d;
    logic [31:0] tmo_q, tmo_d;
    logic        polling_lost_q, polling_lost_d;

    logic latch_rise, latch_fall, clk_fall;

    // Front end: identical synchroniser + glitch filter per line keeps data aligned with clk.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {gamepad_data, gamepad_clk, gamepad_latch};
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
        filt_d = filt_q;
        gcnt_d = gcnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync_q[SYNC_STAGES-1][i] == filt_q[i]) begin
                gcnt_d[i] = '0;
            end else if (gcnt_q[i] == GCW'(GLITCH_CYCLES - 1)) begin
                // GLITCH_CYCLES-th consecutive differing sample: accept the new level.
                filt_d[i] = sync_q[SYNC_STAGES-1][i];
                gcnt_d[i] = '0;
            end else begin
                gcnt_d[i] = gcnt_q[i] + 1'b1;
            end
        end
    end

    // Edges are taken on the filter's next value so the FSM acts in the same edge the
    // filtered line changes; frame completion is then registered one cycle later.
    assign latch_rise = ~filt_q[0] &  filt_d[0];
    assign latch_fall =  filt_q[0] & ~filt_d[0];
    assign clk_fall   =  filt_q[1] & ~filt_d[1];
    assign count_inc  = count_q + 5'd1;

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        shadow_d        = shadow_q;
        done_d          = 1'b0;
        buttons_d       = buttons_q;
        frame_valid_d   = 1'b0;
        frame_changed_d = 1'b0;
        frame_error_d   = 1'b0;
        latch_tick_d    = 1'b0;

        // Publish a completed poll; shadow_q still holds it even if a latch clears shadow_d.
        if (done_q) begin
            buttons_d       = shadow_q;
            frame_valid_d   = 1'b1;
            frame_changed_d = (shadow_q != buttons_q);
        end

        // Latch has priority over a coincident clk fall.
        if (latch_rise) begin
            latch_tick_d  = 1'b1;
            frame_error_d = (state_q == StShift) && (count_q < 5'(FRAME_BITS));
            state_d       = StLatched;
            count_d       = '0;
            shadow_d      = '0;
        end else begin
            unique case (state_q)
                StLatched: begin
                    if (latch_fall) begin
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (clk_fall) begin
                        shadow_d[count_q[3:0]] = ~filt_q[2];
                        count_d                = count_inc;
                        if (count_inc == 5'(FRAME_BITS)) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StIdle: begin
                    // Extra reads past the frame are ignored; count stays saturated.
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        if (latch_rise) begin
            tmo_d = '0;
        end else if (tmo_q == 32'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end
        polling_lost_d = (tmo_d == 32'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q          <= {SYNC_STAGES{LINE_RST}};
            filt_q          <= LINE_RST;
            gcnt_q          <= '0;
            state_q         <= StIdle;
            count_q         <= '0;
            shadow_q        <= '0;
            done_q          <= 1'b0;
            buttons_q       <= '0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            frame_error_q   <= 1'b0;
            latch_tick_q    <= 1'b0;
            tmo_q           <= '0;
            polling_lost_q  <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            filt_q          <= filt_d;
            gcnt_q          <= gcnt_d;
            state_q         <= state_d;
            count_q         <= count_d;
            shadow_q        <= shadow_d;
            done_q          <= done_d;
            buttons_q       <= buttons_d;
            frame_valid_q   <= frame_valid_d;
            frame_changed_q <= frame_changed_d;
            frame_error_q   <= frame_error_d;
            latch_tick_q    <= latch_tick_d;
            tmo_q           <= tmo_d;
            polling_lost_q  <= polling_lost_d;
        end
    end

    assign buttons       = buttons_q;
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;
    assign frame_error   = frame_error_q;
    assign latch_tick    = latch_tick_q;
    assign polling_lost  = polling_lost_q;

endmodule
